// File: rtl/ppc_fetch_unit.sv
// PPC instruction fetch stage: issues doubleword reads, splits each doubleword into
// two 32-bit instructions and buffers them in an in-order FIFO for decode.
module ppc_fetch_unit #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [0:63] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          redirect_valid,
    input  logic [0:63]                   redirect_pc,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [0:60]                   mem_req_addr,
    input  logic                          mem_resp_valid,
    input  logic [0:63]                   mem_resp_data,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [0:31]                   inst,
    output logic [0:63]                   inst_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {FETCH, WAIT, DRAIN} fetchState_t;

    fetchState_t   state, stateNext;
    logic [0:63]   fetchPc;
    logic [0:63]   redirectTarget;
    logic          started;
    logic [AW:0]   count;
    logic [AW:0]   pushNum;
    logic [AW-1:0] rdPtr, wrPtr, wrPtrInc;
    logic [0:31]   instBuf [FIFO_DEPTH];
    logic [0:63]   pcBuf   [FIFO_DEPTH];
    logic          reqFire, respTake, pop;

    assign redirectTarget = redirect_pc & {{62{1'b1}}, 2'b00};
    // started keeps the request low while reset is asserted even though state is FETCH
    assign mem_req_valid  = started && (state == FETCH) && ((DEPTH_CNT - count) >= (AW+1)'(2));
    assign reqFire        = mem_req_valid && mem_req_ready;
    assign mem_req_addr   = fetchPc[0:60];
    assign inst_valid     = (count != '0);
    assign pop            = inst_valid && inst_ready;
    assign inst           = inst_valid ? instBuf[rdPtr] : '0;
    assign inst_pc        = inst_valid ? pcBuf[rdPtr]   : '0;
    assign fifo_count     = count;
    assign wrPtrInc       = wrPtr + AW'(1);

    always_comb begin
        stateNext = state;
        respTake  = 1'b0;
        pushNum   = '0;
        case (state)
            FETCH: begin
                if (reqFire) stateNext = redirect_valid ? DRAIN : WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    stateNext = FETCH;
                    respTake  = !redirect_valid;
                end else if (redirect_valid) begin
                    stateNext = DRAIN;
                end
            end
            // A response arriving alongside a redirect still retires the stale request
            DRAIN: begin
                if (mem_resp_valid) stateNext = FETCH;
            end
            default: stateNext = FETCH;
        endcase
        if (respTake) pushNum = fetchPc[61] ? (AW+1)'(1) : (AW+1)'(2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            started <= 1'b0;
            fetchPc <= RESET_PC;
        end else begin
            state   <= stateNext;
            started <= 1'b1;
            if (redirect_valid)
                fetchPc <= redirectTarget;
            else if (respTake)
                fetchPc <= {fetchPc[0:60] + 61'd1, 3'b000};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
        end else if (redirect_valid) begin
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
        end else begin
            rdPtr <= rdPtr + AW'(pop);
            wrPtr <= wrPtr + AW'(pushNum);
            count <= count + pushNum - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                instBuf[i] <= '0;
                pcBuf[i]   <= '0;
            end
        end else if (respTake) begin
            if (fetchPc[61]) begin
                instBuf[wrPtr] <= mem_resp_data[32:63];
                pcBuf[wrPtr]   <= fetchPc;
            end else begin
                instBuf[wrPtr]    <= mem_resp_data[0:31];
                pcBuf[wrPtr]      <= fetchPc;
                instBuf[wrPtrInc] <= mem_resp_data[32:63];
                pcBuf[wrPtrInc]   <= {fetchPc[0:60], 3'b100};
            end
        end
    end

endmodule

// File: tb/tb_ppc_fetch_unit.sv
// Bench for ppc_fetch_unit: memory model with variable latency and an in-order
// instruction-stream reference (expected next PC / next doubleword per redirect).
module tb_ppc_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [60:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    ppc_fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .fifo_count(fifo_count)
    );

    int nChecks = 0;
    int nFails  = 0;

    // memory model and reference stream state
    bit          pending = 0;
    int          pendCnt = 0;
    logic [60:0] respDw = '0;
    int          memLat = 1;
    bit          spur = 0;
    logic [63:0] expPc = '0;
    logic [60:0] expDw = '0;
    bit          prevHold = 0;
    logic [31:0] prevInst = '0;
    logic [63:0] prevPc = '0;
    int          pops = 0;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [63:0] a);
        if (a == 64'h0) return 32'h3860_0041;
        if (a == 64'h4) return 32'h3800_0000;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] memDw(input logic [60:0] dw);
        logic [63:0] b;
        b = {dw, 3'b000};
        return {memWord(b), memWord(b + 64'd4)};
    endfunction

    task automatic checkResetOutputs(input string tag);
        checkEq({tag, "ReqValid"}, mem_req_valid, 0);
        checkEq({tag, "InstValid"}, inst_valid, 0);
        checkEq({tag, "Inst"}, inst, 0);
        checkEq({tag, "InstPc"}, inst_pc, 0);
        checkEq({tag, "Count"}, fifo_count, 0);
    endtask

    task automatic modelReset();
        pending  = 0;
        prevHold = 0;
        expPc    = '0;
        expDw    = '0;
    endtask

    // One clock: drive inputs at negedge, check against the reference, then cross posedge
    task automatic cycle(input bit rdy, input bit memRdy, input bit redir, input logic [63:0] target);
        @(negedge clk);
        inst_ready     = rdy;
        mem_req_ready  = memRdy;
        redirect_valid = redir;
        redirect_pc    = target;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        if (pending) begin
            pendCnt--;
            if (pendCnt == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = memDw(respDw);
                pending        = 0;
            end
        end else if (spur) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = {$urandom, $urandom};
        end
        #1;
        if (prevHold) begin
            checkEq("holdInst", inst, prevInst);
            checkEq("holdPc", inst_pc, prevPc);
        end
        checkEq("validVsCount", inst_valid, fifo_count != 0);
        if (mem_req_valid) checkEq("reqSpace", fifo_count <= DEPTH - 2, 1);
        if (inst_valid && rdy) begin
            checkEq("popPc", inst_pc, expPc);
            checkEq("popInst", inst, memWord(expPc));
            expPc += 64'd4;
            pops++;
        end
        if (mem_req_valid && memRdy) begin
            checkEq("oneOutstanding", pending, 0);
            checkEq("reqAddr", mem_req_addr, expDw);
            respDw  = mem_req_addr;
            pending = 1;
            pendCnt = memLat;
            expDw   = expDw + 61'd1;
        end
        prevHold = inst_valid && !rdy && !redir;
        prevInst = inst;
        prevPc   = inst_pc;
        if (redir) begin
            expPc = target & ~64'h3;
            expDw = target[63:3];
        end
        @(posedge clk);
        #1;
        if (redir) checkEq("flushCount", fifo_count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d fails=%0d", nChecks, nFails);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int popsBefore;
        logic [63:0] firstPc;
        logic [63:0] target;

        // reset values
        repeat (2) @(negedge clk);
        checkResetOutputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();

        // sustained fetch from RESET_PC with 1-cycle memory
        pops = 0;
        for (int i = 0; i < 20; i++) cycle(1, 1, 0, '0);
        checkEq("t1Pops", pops, 18);

        // decode stall: FIFO fills, requests stop, head holds
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, '0);
        checkEq("t3Full", fifo_count, 4);
        checkEq("t3NoReq", mem_req_valid, 0);
        spur = 1;
        cycle(0, 1, 0, '0);
        spur = 0;
        checkEq("t3SpurCount", fifo_count, 4);
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, '0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, '0);

        // redirect to odd word: single push, then sequential doublewords
        cycle(0, 1, 1, 64'h104);
        checkEq("t2ReqValid", mem_req_valid, 1);
        checkEq("t2ReqAddr", mem_req_addr, 61'h20);
        cycle(0, 1, 0, '0);
        cycle(0, 1, 0, '0);
        checkEq("t2InstValid", inst_valid, 1);
        checkEq("t2InstPc", inst_pc, 64'h104);
        checkEq("t2Count", fifo_count, 1);
        checkEq("t2NextAddr", mem_req_addr, 61'h21);
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, '0);

        // redirect while waiting on a 3-cycle memory
        memLat = 3;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1, 1, 0, '0);
            if (pending && pendCnt == 3) found = 1;
        end
        checkEq("t4Found", found, 1);
        cycle(1, 1, 1, 64'h2000);
        firstPc = '1;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 1, 0, '0);
            if (inst_valid) begin
                firstPc = inst_pc;
                break;
            end
        end
        checkEq("t4FirstPc", firstPc, 64'h2000);
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, '0);

        // redirect coinciding with a response and a pop
        memLat = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1, 1, 0, '0);
            if (pending && pendCnt == 1) found = 1;
        end
        checkEq("t5Found", found, 1);
        cycle(1, 1, 1, 64'h5000);
        checkEq("t5Count", fifo_count, 0);
        checkEq("t5Valid", inst_valid, 0);
        checkEq("t5ReqValid", mem_req_valid, 1);
        checkEq("t5ReqAddr", mem_req_addr, 61'h0A00);
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, '0);

        // asynchronous reset in the middle of a transaction
        memLat = 3;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(0, 1, 0, '0);
            if (pending && pendCnt == 3 && fifo_count != 0) found = 1;
        end
        checkEq("t6Found", found, 1);
        cycle(0, 1, 0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("t6Rst");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        popsBefore = pops;
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, '0);
        checkEq("t6Restart", pops > popsBefore, 1);

        // randomized traffic
        popsBefore = pops;
        for (int i = 0; i < 1500; i++) begin
            bit redir;
            memLat = $urandom_range(1, 3);
            redir  = ($urandom_range(0, 99) < 3);
            case ($urandom_range(0, 3))
                0:       target = 64'hFFFF_FFFF_FFFF_FFE8 + 64'($urandom_range(0, 5) * 4);
                1:       target = {$urandom, $urandom};
                default: target = {32'h0, $urandom_range(0, 32'hFFFF)};
            endcase
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, redir, target);
        end
        checkEq("rndProgress", (pops - popsBefore) > 200, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
